// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   arb_state_e    : tie-break priority state (CPU_PRI after reset, AUX_PRI)
//   ADDR_W, DATA_W : bus widths of both requesters and the memory port
//   WORDS_DEFAULT  : default legal word count of the data memory
package dmem_arb_pkg;

    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned WORDS_DEFAULT = 256;

    typedef enum logic {
        CPU_PRI = 1'b0,
        AUX_PRI = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a combinational-read data memory.
// The CPU pipeline normally wins ties. The auxiliary requester (RSA engine /
// display readout) is guaranteed a grant after STARVE_LIMIT waiting cycles.
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   cpu_req/we/addr/wdata              : CPU request (held until granted)
//   cpu_gnt                            : CPU access performed this cycle
//   cpu_rvalid/cpu_rdata               : CPU read response, 1 cycle latency
//   aux_*                              : same set for the auxiliary requester
//   mem_we/addr/wdata, mem_rdata       : data memory port
//   err                                : sticky out-of-range access flag
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned WORDS        = WORDS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_gnt,
    output logic              aux_rvalid,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    localparam int unsigned       CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] WORDS_L = ADDR_W'(WORDS);

    arb_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_wait_cnt, w_cnt_nxt;
    logic              w_cpu_gnt, w_aux_gnt, w_gnt_any;
    logic              w_sel_we, w_in_range;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata, w_rd_data;
    logic              r_cpu_rvalid, r_aux_rvalid, r_err;
    logic [DATA_W-1:0] r_cpu_rdata, r_aux_rdata;

    // Grants are combinational; both forced low while reset is asserted.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_aux_gnt = 1'b0;
        if (rst_n) begin
            if (cpu_req && aux_req) begin
                if (r_state == AUX_PRI) w_aux_gnt = 1'b1;
                else                    w_cpu_gnt = 1'b1;
            end else begin
                w_cpu_gnt = cpu_req;
                w_aux_gnt = aux_req;
            end
        end
    end

    assign w_gnt_any   = w_cpu_gnt | w_aux_gnt;
    assign w_sel_we    = w_aux_gnt ? aux_we    : (w_cpu_gnt ? cpu_we    : 1'b0);
    assign w_sel_addr  = w_aux_gnt ? aux_addr  : (w_cpu_gnt ? cpu_addr  : '0);
    assign w_sel_wdata = w_aux_gnt ? aux_wdata : (w_cpu_gnt ? cpu_wdata : '0);
    assign w_in_range  = ({2'b00, w_sel_addr[ADDR_W-1:2]} < WORDS_L);
    assign w_rd_data   = w_in_range ? mem_rdata : '0;

    assign mem_we    = w_gnt_any & w_sel_we & w_in_range;
    assign mem_addr  = w_sel_addr;
    assign mem_wdata = w_sel_wdata;

    // Wait counter saturates at STARVE_LIMIT. The state flips on the
    // incremented value so the forced grant lands in the cycle right after
    // the STARVE_LIMIT-th lost tie.
    always_comb begin
        w_cnt_nxt   = r_wait_cnt;
        w_state_nxt = r_state;
        if (!aux_req || w_aux_gnt)      w_cnt_nxt = '0;
        else if (r_wait_cnt != CNT_MAX) w_cnt_nxt = r_wait_cnt + 1'b1;
        case (r_state)
            CPU_PRI: if (w_cnt_nxt == CNT_MAX)     w_state_nxt = AUX_PRI;
            AUX_PRI: if (w_aux_gnt || !aux_req)    w_state_nxt = CPU_PRI;
            default:                               w_state_nxt = CPU_PRI;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= CPU_PRI;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_cnt_nxt;
        end
    end

    // Read responses; rdata holds its last value between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_rvalid <= 1'b0;
            r_aux_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_aux_rdata  <= '0;
            r_err        <= 1'b0;
        end else begin
            r_cpu_rvalid <= w_cpu_gnt & ~cpu_we;
            r_aux_rvalid <= w_aux_gnt & ~aux_we;
            if (w_cpu_gnt && !cpu_we) r_cpu_rdata <= w_rd_data;
            if (w_aux_gnt && !aux_we) r_aux_rdata <= w_rd_data;
            r_err <= r_err | (w_gnt_any & ~w_in_range);
        end
    end

    assign cpu_gnt    = w_cpu_gnt;
    assign aux_gnt    = w_aux_gnt;
    assign cpu_rvalid = r_cpu_rvalid;
    assign aux_rvalid = r_aux_rvalid;
    assign cpu_rdata  = r_cpu_rdata;
    assign aux_rdata  = r_aux_rdata;
    assign err        = r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data memory and a
// per-requester queue of expected read responses.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        aux_req = 1'b0, aux_we = 1'b0;
    logic [31:0] aux_addr = '0, aux_wdata = '0;
    logic        aux_gnt, aux_rvalid;
    logic [31:0] aux_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        err;

    logic [31:0] mem [0:255];
    logic [31:0] cpu_q[$];
    logic [31:0] aux_q[$];
    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    dmem_arbiter #(.STARVE_LIMIT(4), .WORDS(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int unsigned i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    // Memory contents are (re)loaded with a known pattern while in reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
        end else if (mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[9:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One arbitration cycle: inputs are already driven (at a negedge).
    // Check grants, clock once, then check the responses queued for it.
    task automatic cyc(input logic ecg, input logic eag);
        logic [31:0] d;
        #1;
        chk("cpu_gnt", {31'b0, cpu_gnt}, {31'b0, ecg});
        chk("aux_gnt", {31'b0, aux_gnt}, {31'b0, eag});
        @(posedge clk);
        @(negedge clk);
        if (cpu_q.size() > 0) begin
            d = cpu_q.pop_front();
            chk("cpu_rvalid", {31'b0, cpu_rvalid}, 32'd1);
            chk("cpu_rdata", cpu_rdata, d);
        end else begin
            chk("cpu_rvalid_idle", {31'b0, cpu_rvalid}, 32'd0);
        end
        if (aux_q.size() > 0) begin
            d = aux_q.pop_front();
            chk("aux_rvalid", {31'b0, aux_rvalid}, 32'd1);
            chk("aux_rdata", aux_rdata, d);
        end else begin
            chk("aux_rvalid_idle", {31'b0, aux_rvalid}, 32'd0);
        end
    endtask

    initial begin
        // Reset state, with both requests pending
        cpu_req = 1'b1; aux_req = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_cpu_gnt", {31'b0, cpu_gnt}, 32'd0);
        chk("rst_aux_gnt", {31'b0, aux_gnt}, 32'd0);
        chk("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);

        // Tie at reset: CPU first, aux next as sole requester
        @(negedge clk);
        rst_n = 1'b1;
        cpu_we = 1'b0; cpu_addr = 32'h10;
        aux_we = 1'b0; aux_addr = 32'h20;
        cpu_q.push_back(pat(4));
        cyc(1'b1, 1'b0);
        cpu_req = 1'b0;
        #1 chk("sole_mem_addr", mem_addr, 32'h20);
        aux_q.push_back(pat(8));
        cyc(1'b0, 1'b1);
        aux_req = 1'b0;
        #1 chk("idle_mem_addr", mem_addr, 32'h0);
        cyc(1'b0, 1'b0);
        chk("cpu_rdata_hold", cpu_rdata, pat(4));

        // Starvation: aux forced in cycle 4, exactly once
        cpu_req = 1'b1; cpu_addr = 32'h0;
        aux_req = 1'b1; aux_addr = 32'h4;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                aux_q.push_back(pat(1));
                cyc(1'b0, 1'b1);
            end else begin
                cpu_q.push_back(pat(0));
                cyc(1'b1, 1'b0);
            end
        end
        cpu_req = 1'b0; aux_req = 1'b0;
        cyc(1'b0, 1'b0);

        // Aux write then CPU read of the same word
        aux_req = 1'b1; aux_we = 1'b1; aux_addr = 32'h40; aux_wdata = 32'hDEADBEEF;
        #1 chk("aux_wr_mem_we", {31'b0, mem_we}, 32'd1);
        cyc(1'b0, 1'b1);
        aux_req = 1'b0; aux_we = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        cpu_q.push_back(32'hDEADBEEF);
        cyc(1'b1, 1'b0);

        // Last legal word, then word 256 out of range
        cpu_addr = 32'h3FC;
        cpu_q.push_back(pat(255));
        cyc(1'b1, 1'b0);
        chk("err_in_range", {31'b0, err}, 32'd0);
        cpu_we = 1'b1; cpu_addr = 32'h400; cpu_wdata = 32'h1234_5678;
        #1 chk("oor_mem_we", {31'b0, mem_we}, 32'd0);
        cyc(1'b1, 1'b0);
        chk("oor_err_set", {31'b0, err}, 32'd1);
        chk("oor_no_write", mem[0], pat(0));
        cpu_we = 1'b0;
        cpu_q.push_back(32'h0);
        cyc(1'b1, 1'b0);
        cpu_req = 1'b0;
        cyc(1'b0, 1'b0);
        chk("err_sticky", {31'b0, err}, 32'd1);

        // Reset in the cycle after a granted read, with aux starved
        cpu_req = 1'b1; cpu_addr = 32'h8;
        aux_req = 1'b1; aux_addr = 32'hC;
        for (int i = 0; i < 3; i++) begin
            cpu_q.push_back(pat(2));
            cyc(1'b1, 1'b0);
        end
        #1 chk("pre_rst_cpu_gnt", {31'b0, cpu_gnt}, 32'd1);
        @(posedge clk);
        #2;
        chk("pre_rst_rvalid", {31'b0, cpu_rvalid}, 32'd1);
        chk("pre_rst_rdata", cpu_rdata, pat(2));
        chk("pre_rst_state", 32'(dut.r_state), 32'(AUX_PRI));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", {31'b0, cpu_rvalid}, 32'd0);
        chk("mid_rst_rdata", cpu_rdata, 32'd0);
        chk("mid_rst_cpu_gnt", {31'b0, cpu_gnt}, 32'd0);
        chk("mid_rst_aux_gnt", {31'b0, aux_gnt}, 32'd0);
        chk("mid_rst_err", {31'b0, err}, 32'd0);
        chk("mid_rst_state", 32'(dut.r_state), 32'(CPU_PRI));
        chk("mid_rst_cnt", 32'(dut.r_wait_cnt), 32'd0);
        @(negedge clk);
        cpu_req = 1'b0; aux_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameters: STARVE_LIMIT, default 4, max consecutive cycles aux waits before forced grant; WORDS, default 256, legal word count of data memory.
REQ-002 SHALL have port clk  in  1  single clock, all state on posedge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cpu_req  in  1  CPU pipeline access request.
REQ-005 SHALL have port cpu_we  in  1  CPU write enable, qualified by cpu_req.
REQ-006 SHALL have ports cpu_addr / cpu_wdata  in  32 / 32  CPU byte address / write data.
REQ-007 SHALL have port cpu_gnt  out  1  CPU access performed this cycle.
REQ-008 SHALL have ports cpu_rvalid / cpu_rdata  out  1 / 32  CPU read response.
REQ-009 SHALL have ports aux_req, aux_we, aux_addr, aux_wdata, aux_gnt, aux_rvalid, aux_rdata with the same directions, widths and meanings for the auxiliary (RSA engine / display readout) requester.
REQ-010 SHALL have ports mem_we  out  1; mem_addr  out  32; mem_wdata  out  32; mem_rdata  in  32  (combinational-read data memory).
REQ-011 SHALL have port err  out  1  sticky out-of-range access flag.

Function
REQ-012 SHALL grant at most one requester per cycle; cpu_gnt and aux_gnt combinational from req and FSM state, never both high.
REQ-013 SHALL drive mem_* from the granted requester; with no grant mem_we=0, mem_addr=0, mem_wdata=0.
REQ-014 SHALL require requesters to hold req/we/addr/wdata stable until gnt observed high at a posedge; dropping req early is legal, no access occurs.
REQ-015 SHALL implement FSM CPU_PRI (reset) and AUX_PRI: in CPU_PRI cpu wins ties; in AUX_PRI aux wins ties.
REQ-016 SHALL keep a saturating wait counter, width clog2(STARVE_LIMIT+1): +1 each cycle aux_req=1 and aux_gnt=0; cleared on aux_gnt or aux_req=0.
REQ-017 SHALL transition CPU_PRI->AUX_PRI when counter reaches STARVE_LIMIT; AUX_PRI->CPU_PRI after one aux grant, or if aux_req=0.
REQ-018 SHALL grant the sole requester immediately regardless of state.
REQ-019 SHALL register mem_rdata on a granted read; requester's rvalid high exactly one cycle later for one cycle with rdata; latency 1 cycle; back-to-back reads give rvalid every cycle.
REQ-020 SHALL hold rdata at last value when rvalid=0; writes produce no rvalid.
REQ-021 SHALL treat an access as out of range when addr[31:2] >= WORDS: write suppressed (mem_we=0), read returns rdata=0 with rvalid, gnt still asserted, err set.
REQ-022 SHALL keep err set until reset.
REQ-023 SHALL not reorder: an aux write followed next cycle by a cpu read of the same address returns the written data.

Reset
REQ-024 SHALL on rst_n=0 asynchronously force: FSM=CPU_PRI, counter=0, cpu_rvalid=aux_rvalid=0, cpu_rdata=aux_rdata=0, err=0; gnt outputs 0 while rst_n=0.
REQ-025 SHALL discard any in-flight read response when reset asserts mid-transfer; no rvalid after release without a new grant.

Structure
REQ-026 SHALL place state enum (CPU_PRI, AUX_PRI), address/data width constants and WORDS default in shared package dmem_arb_pkg.
REQ-027 SHALL be a single module, no sub-modules; instantiated between the pipeline memory stage and dmem.

Verification
REQ-028 Both req reads at reset state, cpu_addr=0x10, aux_addr=0x20 -> cpu_gnt=1 cycle 0, cpu_rvalid cycle 1 with mem[4]; aux_gnt waits.
REQ-029 cpu_req held high 8 cycles, aux_req held high, STARVE_LIMIT=4 -> aux_gnt in cycle 4 exactly once, then cpu resumes cycle 5.
REQ-030 aux write 0xDEADBEEF to 0x40, next cycle cpu read 0x40 -> cpu_rdata=0xDEADBEEF, cpu_rvalid one cycle after grant.
REQ-031 cpu write to 0x400 (word 256) -> mem_we=0, err=1 and stays 1; cpu read 0x400 -> rdata=0, rvalid=1.
REQ-032 rst_n low in cycle after granted read -> rvalid=0, rdata=0, FSM=CPU_PRI, counter=0 immediately; no rvalid after release.
